// File: rtl/rx_cic_ctrl.sv
// Rate-change sequencer around a CIC decimator: drain, reset, settle, run.
// Optional drop counter enabled by defining RX_CIC_CTRL_DROP_CNT_EN.
module rx_cic_ctrl #(
  parameter logic [10:0] RATE_DEFAULT  = 11'd160,
  parameter logic [10:0] RATE_MIN      = 11'd4,
  parameter int          RESET_CYCLES  = 8,
  parameter int          SETTLE_FRAMES = 5,
  parameter int          DRAIN_TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] cfg_rate,
  input  logic        cfg_wr,
  output logic        cfg_busy,
  output logic        cfg_err,
  input  logic        src_valid,
  output logic        src_ready,
  output logic        cic_in_valid,
  input  logic        cic_in_ready,
  output logic [10:0] cic_rate,
  output logic        cic_reset_n,
  input  logic        cic_out_valid,
  input  logic        cic_out_endofpacket,
  output logic        cic_out_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    CRST,
    SETTLE
  } state_t;

  localparam logic [15:0] DRAIN_LAST  = 16'(DRAIN_TIMEOUT - 1);
  localparam logic [15:0] RST_LAST    = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_FRAMES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [10:0] pend_q;
  logic [10:0] rate_q;
  logic        err_q;
  logic        wr_ok;
  logic        wr_bad;

  assign wr_ok    = cfg_wr && (state_q == RUN)
                    && (cfg_rate >= RATE_MIN);
  assign wr_bad   = cfg_wr && !wr_ok;
  assign cfg_err  = err_q && !wr_ok;
  assign cic_rate = rate_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    src_ready     = 1'b0;
    cic_in_valid  = 1'b0;
    out_valid     = 1'b0;
    cic_out_ready = 1'b1;
    cic_reset_n   = 1'b1;
    cfg_busy      = 1'b1;
    unique case (state_q)
      RUN: begin
        src_ready     = cic_in_ready;
        cic_in_valid  = src_valid;
        out_valid     = cic_out_valid;
        cic_out_ready = out_ready;
        cfg_busy      = 1'b0;
        if (wr_ok) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        out_valid     = cic_out_valid;
        cic_out_ready = out_ready;
        cnt_d         = cnt_q + 16'd1;
        if ((cic_out_valid && out_ready
             && cic_out_endofpacket)
            || (cnt_q == DRAIN_LAST)) begin
          state_d = CRST;
          cnt_d   = '0;
        end
      end
      CRST: begin
        cic_reset_n = 1'b0;
        cnt_d       = cnt_q + 16'd1;
        if (cnt_q == RST_LAST) begin
          cnt_d = '0;
          if (SETTLE_FRAMES == 0) state_d = RUN;
          else                    state_d = SETTLE;
        end
      end
      SETTLE: begin
        src_ready    = cic_in_ready;
        cic_in_valid = src_valid;
        // every beat is accepted and dropped; count frame ends
        if (cic_out_valid && cic_out_endofpacket) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == SETTLE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = CRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= CRST;
      cnt_q   <= '0;
      rate_q  <= RATE_DEFAULT;
      pend_q  <= RATE_DEFAULT;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (wr_ok) pend_q <= cfg_rate;
      if (state_q == DRAIN && state_d == CRST)
        rate_q <= pend_q;
      if (wr_ok)       err_q <= 1'b0;
      else if (wr_bad) err_q <= 1'b1;
    end
  end

`ifdef RX_CIC_CTRL_DROP_CNT_EN
  logic        drop_ev;
  logic [15:0] drop_q;

  assign drop_ev = src_valid && !src_ready
                   && (state_q != RUN);

  always_ff @(posedge clk) begin
    if (!reset_n)
      drop_q <= '0;
    else if (wr_ok)
      drop_q <= '0;
    else if (drop_ev && drop_q != 16'hFFFF)
      drop_q <= drop_q + 16'd1;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: doc/rx_cic_ctrl.md
RX_CIC_CTRL -- requirements
Module: rx_cic_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): RATE_DEFAULT, 11'd160, decimation rate loaded at reset; RATE_MIN, 11'd4, lowest legal rate; RESET_CYCLES, 8, length of the CIC reset pulse; SETTLE_FRAMES, 5, output frames discarded after a CIC reset; DRAIN_TIMEOUT, 4095, maximum number of DRAIN cycles.
REQ-002 The block SHALL have one clock, clk; reset_n SHALL be synchronous and active-low.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- cfg_rate  in  11  requested decimation rate
- cfg_wr  in  1  one-cycle rate-write strobe
- cfg_busy  out  1  rate change in progress
- cfg_err  out  1  sticky error: rejected write
- src_valid  in  1  upstream sample valid
- src_ready  out  1  upstream ready
- cic_in_valid  out  1  valid to the CIC
- cic_in_ready  in  1  ready from the CIC
- cic_rate  out  11  rate to the CIC
- cic_reset_n  out  1  CIC reset
- cic_out_valid  in  1  CIC output valid
- cic_out_endofpacket  in  1  CIC last channel of a frame
- cic_out_ready  out  1  ready to the CIC
- out_valid  out  1  gated output valid
- out_ready  in  1  downstream ready
- drop_cnt  out  16  dropped-input-sample count

Function
REQ-004 The FSM SHALL have four states: RUN, DRAIN, CRST and SETTLE.
REQ-005 In RUN, cic_in_valid SHALL equal src_valid, src_ready SHALL equal cic_in_ready, out_valid SHALL equal cic_out_valid, and cic_out_ready SHALL equal out_ready.
REQ-006 In RUN, a cfg_wr with cfg_rate >= RATE_MIN SHALL latch cfg_rate into a pending register and move the FSM to DRAIN on the next cycle.
REQ-007 A cfg_wr with cfg_rate < RATE_MIN SHALL be ignored and SHALL set cfg_err.
REQ-008 A cfg_wr in any state other than RUN SHALL be ignored and SHALL set cfg_err.
REQ-009 cfg_err SHALL clear only on an accepted cfg_wr; an accepted write SHALL clear cfg_err in the same cycle it is accepted.
REQ-010 In DRAIN, src_ready and cic_in_valid SHALL be 0; the output path SHALL behave as in RUN.
REQ-011 DRAIN SHALL exit to CRST on the first cycle where cic_out_valid, cic_out_ready and cic_out_endofpacket are all 1, or after DRAIN_TIMEOUT cycles, whichever comes first.
REQ-012 On entry to CRST, cic_rate SHALL load the pending rate; cic_reset_n SHALL be 0 for exactly RESET_CYCLES cycles; src_ready, cic_in_valid and out_valid SHALL be 0; cic_out_ready SHALL be 1.
REQ-013 CRST SHALL then go to SETTLE.
REQ-014 In SETTLE, the input path SHALL behave as in RUN; out_valid SHALL be 0 and cic_out_ready SHALL be 1, so all CIC output is discarded.
REQ-015 SETTLE SHALL return to RUN after SETTLE_FRAMES accepted endofpacket beats; the beat that completes the count SHALL itself be discarded.
REQ-016 cfg_busy SHALL be 1 in every state except RUN.
REQ-017 If SETTLE_FRAMES is 0, CRST SHALL go directly to RUN.
REQ-018 Each beat on which src_valid=1 and src_ready=0 in a non-RUN state SHALL count as one dropped sample.

Reset
REQ-019 While reset_n=0 at a clk edge: FSM to CRST with the RESET_CYCLES counter restarted; cic_rate=RATE_DEFAULT; cic_reset_n=0; src_ready=0; cic_in_valid=0; out_valid=0; cic_out_ready=1; cfg_busy=1; cfg_err=0; drop_cnt=0; pending rate=RATE_DEFAULT.
REQ-020 After reset, the block SHALL run the CRST then SETTLE sequence before entering RUN.
REQ-021 Reset asserted mid-sequence SHALL abandon the pending rate and restart from REQ-019.

Configuration
REQ-022 With RX_CIC_CTRL_DROP_CNT_EN defined, drop_cnt SHALL increment by 1 per dropped sample (REQ-018), saturate at 16'hFFFF, and clear on an accepted cfg_wr.
REQ-023 Without RX_CIC_CTRL_DROP_CNT_EN, drop_cnt SHALL be tied to 0 and no counter logic SHALL be synthesized.

Verification
REQ-024 Release reset -> cic_reset_n low for 8 cycles; cic_rate=160; the first 5 frames are discarded; cfg_busy falls; out_valid then follows cic_out_valid.
REQ-025 In RUN, write cfg_rate=11'd64 mid-frame -> src_ready=0 until endofpacket; 8-cycle cic_reset_n pulse; cic_rate=64; 5 frames discarded; return to RUN.
REQ-026 Write cfg_rate=11'd3 -> cfg_err=1; state, cic_rate and cfg_busy unchanged; a later write of 11'd100 clears cfg_err.
REQ-027 Write during SETTLE -> write ignored; cfg_err=1; cic_rate unchanged.
REQ-028 Hold endofpacket at 0 in DRAIN -> CRST entered exactly 4095 cycles after DRAIN entry.
REQ-029 With RX_CIC_CTRL_DROP_CNT_EN defined, hold src_valid=1 through one full rate change of 30 non-RUN cycles -> drop_cnt=30; the next accepted write -> drop_cnt=0.
